// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the datapath-side request/response signals and the
// RAM-side port of the single-port memory arbiter.
//   iREN/iaddr -> iload/ihit          : instruction fetch channel
//   dREN/dWEN/daddr/dstore -> dload/dhit : data load/store channel
//   ramREN/ramWEN/ramaddr/ramstore     : shared RAM command port
//   ramload/ramstate                   : RAM response (0 FREE,1 BUSY,2 ACCESS,3 ERROR)
//   mem_err                            : sticky error flag
// Modports:
//   slave  - the arbiter itself
//   master - the environment (datapath + RAM) around the arbiter
interface mem_arbiter_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [WORD_W-1:0] iload;
  logic              ihit;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic [WORD_W-1:0] dload;
  logic              dhit;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  logic              mem_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data access.
// Data requests have priority over fetches. One request is latched in IDLE and
// served until the RAM reports ACCESS (hit), ERROR, a timeout, or the requester
// withdraws / changes address (abort). Every service ends by passing through
// IDLE, and every failed/aborted service additionally passes through RECOVER.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - mem_arbiter_if.slave (datapath channels, RAM port, mem_err)
// Parameters: WORD_W data width, ADDR_W address width, TIMEOUT max service
// cycles before the service is abandoned with an error (>= 1).
module mem_arbiter #(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DSERV   = 2'd1,
    ISERV   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              wr_reg, wr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [WORD_W-1:0] store_reg, store_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_reg, err_next;

  logic abort;
  logic ram_ren, ram_wen;
  logic ihit, dhit;
  logic in_service;

  assign in_service = (state_reg == DSERV) || (state_reg == ISERV);

  // The requester withdrawing or moving its address invalidates the latched
  // request; this also overrides an ACCESS arriving in the same cycle.
  always_comb begin
    abort = 1'b0;
    case (state_reg)
      DSERV:   abort = !(bus.dREN || bus.dWEN) || (bus.daddr != addr_reg);
      ISERV:   abort = !bus.iREN || (bus.iaddr != addr_reg);
      default: abort = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    wr_next    = wr_reg;
    addr_next  = addr_reg;
    store_next = store_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    ihit       = 1'b0;
    dhit       = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (bus.dREN || bus.dWEN) begin
          // dREN together with dWEN is a write
          wr_next    = bus.dWEN;
          addr_next  = bus.daddr;
          store_next = bus.dstore;
          state_next = DSERV;
        end else if (bus.iREN) begin
          wr_next    = 1'b0;
          addr_next  = bus.iaddr;
          state_next = ISERV;
        end
      end

      DSERV, ISERV: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (abort) begin
          cnt_next   = '0;
          state_next = RECOVER;
        end else begin
          // wr_reg is always clear for a fetch
          ram_ren = !wr_reg;
          ram_wen = wr_reg;
          if (bus.ramstate == RAM_ACCESS) begin
            dhit       = (state_reg == DSERV);
            ihit       = (state_reg == ISERV);
            cnt_next   = '0;
            state_next = IDLE;
          end else if (bus.ramstate == RAM_ERROR) begin
            err_next   = 1'b1;
            cnt_next   = '0;
            state_next = RECOVER;
          end else if (cnt_reg == CNT_LAST) begin
            // this is service cycle TIMEOUT and the RAM still has not answered
            err_next   = 1'b1;
            cnt_next   = '0;
            state_next = RECOVER;
          end
        end
      end

      RECOVER: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      store_reg <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wr_reg    <= wr_next;
      addr_reg  <= addr_next;
      store_reg <= store_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = in_service ? addr_reg : '0;
  assign bus.ramstore = (state_reg == DSERV && wr_reg) ? store_reg : '0;
  assign bus.ihit     = ihit;
  assign bus.dhit     = dhit;
  // Read data is passed straight through on the hit cycle; a write hit returns 0.
  assign bus.iload    = ihit ? bus.ramload : '0;
  assign bus.dload    = (dhit && !wr_reg) ? bus.ramload : '0;
  assign bus.mem_err  = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

  localparam int K_FETCH = 0, K_READ = 1, K_WRITE = 2, K_BOTH = 3,
                 K_COMBO = 4, K_IABORT = 5, K_DABORT = 6;

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  mem_arbiter_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit          is_d;
    int          at;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  // RAM content as seen by the responder (keyed by the DUT's ramaddr) and the
  // reference memory (keyed by the addresses the bench requested).
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  // RAM responder controls and expected RAM command
  int          lat = 0;
  bit          err_once = 1'b0;
  int          svc = 0;
  bit          ex_ren = 1'b0, ex_wen = 1'b0;
  logic [31:0] ex_addr = '0, ex_store = '0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask

  // RAM model: answers after `lat` BUSY cycles, or with ERROR once if armed.
  initial begin
    bus.ramstate = S_FREE;
    bus.ramload  = '0;
    forever begin
      @(negedge CLK);
      #1;
      if (bus.ramREN || bus.ramWEN) begin
        svc++;
        check("ram_ren", 64'(bus.ramREN), 64'(ex_ren));
        check("ram_wen", 64'(bus.ramWEN), 64'(ex_wen));
        check("ram_addr", 64'(bus.ramaddr), 64'(ex_addr));
        if (ex_wen) check("ram_store", 64'(bus.ramstore), 64'(ex_store));
        if (err_once) begin
          bus.ramstate = S_ERROR;
          bus.ramload  = $urandom;
          err_once     = 1'b0;
        end else if (svc > lat) begin
          bus.ramstate = S_ACCESS;
          if (bus.ramWEN) begin
            ram_mem[bus.ramaddr] = bus.ramstore;
            bus.ramload = $urandom;
          end else begin
            bus.ramload = ram_rd(bus.ramaddr);
          end
        end else begin
          bus.ramstate = S_BUSY;
          bus.ramload  = $urandom;
        end
      end else begin
        svc = 0;
        bus.ramstate = S_FREE;
        bus.ramload  = $urandom;
      end
    end
  end

  // Monitor: every hit pulse must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (bus.ihit || bus.dhit) begin
        check("hit_exclusive", 64'(bus.ihit & bus.dhit), 64'd0);
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_hit: got ihit=%b dhit=%b, required no hit (cycle %0d)",
                   bus.ihit, bus.dhit, cyc);
        end else begin
          e = sb.pop_front();
          check("hit_kind_dhit", 64'(bus.dhit), 64'(e.is_d));
          check("hit_cycle", 64'(cyc), 64'(e.at));
          if (e.is_d) check("dload", 64'(bus.dload), 64'(e.data));
          else        check("iload", 64'(bus.iload), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  // One transaction starting at the current negedge with the DUT in IDLE.
  // Returns at the negedge where the DUT is back in IDLE and inputs may change.
  task automatic do_txn(input int kind, input logic [31:0] a, input logic [31:0] a2,
                        input logic [31:0] d, input int n, input bit rd);
    int c0;
    c0 = cyc;
    lat = n;
    $display("txn kind=%0d addr=0x%0h addr2=0x%0h data=0x%0h busy=%0d rd=%0d cycle=%0d",
             kind, a, a2, d, n, rd, c0);
    case (kind)
      K_FETCH: begin
        bus.iREN = 1'b1; bus.iaddr = a;
        ex_ren = 1'b1; ex_wen = 1'b0; ex_addr = a;
        sb.push_back('{is_d: 1'b0, at: c0 + 1 + n, data: ref_rd(a)});
        wait_until(c0 + 2 + n);
      end
      K_READ: begin
        bus.dREN = 1'b1; bus.daddr = a;
        ex_ren = 1'b1; ex_wen = 1'b0; ex_addr = a;
        sb.push_back('{is_d: 1'b1, at: c0 + 1 + n, data: ref_rd(a)});
        wait_until(c0 + 2 + n);
      end
      K_WRITE, K_BOTH: begin
        bus.dWEN = 1'b1; bus.dREN = (kind == K_BOTH); bus.daddr = a; bus.dstore = d;
        ex_ren = 1'b0; ex_wen = 1'b1; ex_addr = a; ex_store = d;
        sb.push_back('{is_d: 1'b1, at: c0 + 1 + n, data: 32'h0});
        ref_mem[a] = d;
        wait_until(c0 + 2 + n);
      end
      K_COMBO: begin
        // data and fetch requested together: data first, fetch after IDLE
        bus.iREN = 1'b1; bus.iaddr = a2;
        bus.dREN = rd; bus.dWEN = !rd; bus.daddr = a; bus.dstore = d;
        ex_ren = rd; ex_wen = !rd; ex_addr = a; ex_store = d;
        sb.push_back('{is_d: 1'b1, at: c0 + 1 + n, data: rd ? ref_rd(a) : 32'h0});
        if (!rd) ref_mem[a] = d;
        sb.push_back('{is_d: 1'b0, at: c0 + 3 + 2 * n, data: ref_rd(a2)});
        wait_until(c0 + 2 + n);
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
        ex_ren = 1'b1; ex_wen = 1'b0; ex_addr = a2;
        wait_until(c0 + 4 + 2 * n);
      end
      K_IABORT: begin
        // PC redirect in the first service cycle: RECOVER, then refetch at a2
        bus.iREN = 1'b1; bus.iaddr = a;
        ex_ren = 1'b1; ex_wen = 1'b0; ex_addr = a;
        sb.push_back('{is_d: 1'b0, at: c0 + 4 + n, data: ref_rd(a2)});
        wait_until(c0 + 1);
        bus.iaddr = a2; ex_addr = a2;
        #1;
        check("iabort_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
        wait_until(c0 + 5 + n);
      end
      default: begin
        // data requester withdraws in the first service cycle
        bus.dREN = rd; bus.dWEN = !rd; bus.daddr = a; bus.dstore = d;
        ex_ren = rd; ex_wen = !rd; ex_addr = a; ex_store = d;
        wait_until(c0 + 1);
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
        #1;
        check("dabort_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
        wait_until(c0 + 3);
      end
    endcase
    idle_inputs();
  endtask

  initial begin
    int c0;
    int kind;
    int n;
    logic [31:0] a, a2, d;

    idle_inputs();
    bus.iaddr  = '0;
    bus.daddr  = '0;
    bus.dstore = '0;
    ram_mem[32'h40] = 32'h8C01_0004;
    ref_mem[32'h40] = 32'h8C01_0004;

    // reset state
    repeat (3) @(negedge CLK);
    check("reset_ramREN", 64'(bus.ramREN), 64'd0);
    check("reset_ramWEN", 64'(bus.ramWEN), 64'd0);
    check("reset_ramaddr", 64'(bus.ramaddr), 64'd0);
    check("reset_hits", 64'({bus.ihit, bus.dhit}), 64'd0);
    check("reset_mem_err", 64'(bus.mem_err), 64'd0);
    nRST = 1'b1;
    @(negedge CLK);

    // fetch 0x40 with two BUSY cycles, hit in service cycle 3
    do_txn(K_FETCH, 32'h40, 32'h0, 32'h0, 2, 1'b1);
    // write 0x100 together with a fetch, zero-wait RAM: dhit cycle 1, ihit cycle 3
    do_txn(K_COMBO, 32'h100, 32'h44, 32'hDEAD_BEEF, 0, 1'b0);
    // fetch at 0x40 redirected to 0x80 while BUSY
    do_txn(K_IABORT, 32'h40, 32'h80, 32'h0, 2, 1'b1);
    // dREN and dWEN together act as a write
    do_txn(K_BOTH, 32'h104, 32'h0, 32'h1234_5678, 1, 1'b0);
    do_txn(K_READ, 32'h104, 32'h0, 32'h0, 0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 6));
      a    = 32'h100 + 32'(4 * $urandom_range(0, 7));
      a2   = (kind == K_IABORT) ? (a ^ 32'h20) : (32'h100 + 32'(4 * $urandom_range(0, 7)));
      d    = $urandom;
      n    = (kind >= K_IABORT) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
      do_txn(kind, a, a2, d, n, 1'($urandom_range(0, 1)));
    end
    check("no_err_after_random", 64'(bus.mem_err), 64'd0);

    // timeout: RAM stuck BUSY, error on service cycle 15, request retried after IDLE
    c0 = cyc;
    $display("txn timeout addr=0x108 cycle=%0d", c0);
    lat = 1000;
    bus.dREN = 1'b1; bus.daddr = 32'h108;
    ex_ren = 1'b1; ex_wen = 1'b0; ex_addr = 32'h108;
    sb.push_back('{is_d: 1'b1, at: c0 + 18, data: ref_rd(32'h108)});
    wait_until(c0 + 15);
    check("timeout_strobe_held", 64'(bus.ramREN), 64'd1);
    check("timeout_err_before", 64'(bus.mem_err), 64'd0);
    wait_until(c0 + 16);
    check("timeout_err_set", 64'(bus.mem_err), 64'd1);
    check("timeout_recover_strobe", 64'(bus.ramREN), 64'd0);
    lat = 0;
    wait_until(c0 + 19);
    idle_inputs();
    check("timeout_err_sticky", 64'(bus.mem_err), 64'd1);

    // asynchronous reset in the middle of a data write service
    c0 = cyc;
    $display("txn reset_mid_service addr=0x10c cycle=%0d", c0);
    lat = 5;
    bus.dWEN = 1'b1; bus.daddr = 32'h10C; bus.dstore = 32'hCAFE_F00D;
    ex_ren = 1'b0; ex_wen = 1'b1; ex_addr = 32'h10C; ex_store = 32'hCAFE_F00D;
    wait_until(c0 + 2);
    check("pre_reset_strobe", 64'(bus.ramWEN), 64'd1);
    #3;
    nRST = 1'b0;
    #1;
    check("async_rst_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
    check("async_rst_hits", 64'({bus.ihit, bus.dhit}), 64'd0);
    check("async_rst_mem_err", 64'(bus.mem_err), 64'd0);
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    do_txn(K_READ, 32'h10C, 32'h0, 32'h0, 1, 1'b1);

    // RAM ERROR on a data read: sticky error, RECOVER, retried after IDLE
    c0 = cyc;
    $display("txn ram_error addr=0x110 cycle=%0d", c0);
    lat = 0;
    err_once = 1'b1;
    bus.dREN = 1'b1; bus.daddr = 32'h110;
    ex_ren = 1'b1; ex_wen = 1'b0; ex_addr = 32'h110;
    sb.push_back('{is_d: 1'b1, at: c0 + 4, data: ref_rd(32'h110)});
    wait_until(c0 + 1);
    check("error_err_before", 64'(bus.mem_err), 64'd0);
    wait_until(c0 + 2);
    check("error_err_set", 64'(bus.mem_err), 64'd1);
    check("error_recover_strobe", 64'(bus.ramREN), 64'd0);
    wait_until(c0 + 5);
    idle_inputs();

    do_txn(K_READ, 32'h100, 32'h0, 32'h0, 0, 1'b1);
    do_txn(K_FETCH, 32'h80, 32'h0, 32'h0, 1, 1'b1);
    check("error_err_sticky", 64'(bus.mem_err), 64'd1);

    wait_until(cyc + 4);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
